// File: rtl/flash_ctrl.sv
// Bus-to-flash controller: array read/program, keyed erase with timeout,
// and a small KEY/CMD/STATUS register window.
module flash_ctrl #(
   parameter logic [31:0] UNLOCK_KEY    = 32'hA5A5_5A5A,
   parameter logic [15:0] ERASE_TIMEOUT = 16'd64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [12:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ack,
   output logic        bus_err,
   output logic [31:0] bus_rdata,
   output logic        fl_rd_en,
   output logic        fl_wr_en,
   output logic        fl_erase_en,
   output logic [11:0] fl_addr,
   output logic [31:0] fl_data_in,
   input  logic [31:0] fl_data_out,
   input  logic        fl_busy
);

   typedef enum logic [2:0] {
      IDLE, RD, RD_DATA, PROG, ERASE, ERASE_WAIT, ACK
   } state_t;

   localparam logic [1:0] R_KEY    = 2'd0;
   localparam logic [1:0] R_CMD    = 2'd1;
   localparam logic [1:0] R_STATUS = 2'd2;

   state_t      state_q, state_d;
   logic [9:0]  addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        unl_q, unl_d;
   logic        pe_q, pe_set, pe_clr;
   logic        et_q, et_set, et_clr;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] status;

   assign status = {28'b0, et_q, pe_q, 1'b0, unl_q};

   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      unl_d       = unl_q;
      cnt_d       = cnt_q;
      pe_set      = 1'b0;
      pe_clr      = 1'b0;
      et_set      = 1'b0;
      et_clr      = 1'b0;
      fl_rd_en    = 1'b0;
      fl_wr_en    = 1'b0;
      fl_erase_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus_req) begin
               state_d = ACK;
               err_d   = 1'b0;
               rdata_d = '0;
               if (!bus_addr[12]) begin
                  if (bus_addr[11:10] != 2'b00) begin
                     err_d = 1'b1;
                  end else if (!bus_we) begin
                     state_d = RD;
                  end else if (unl_q) begin
                     state_d = PROG;
                  end else begin
                     err_d  = 1'b1;
                     pe_set = 1'b1;
                  end
               end else begin
                  case (bus_addr[1:0])
                     R_KEY: begin
                        if (bus_we) unl_d = (bus_wdata == UNLOCK_KEY);
                     end
                     R_CMD: begin
                        // lock request takes priority over erase
                        if (bus_we && bus_wdata[1]) begin
                           unl_d = 1'b0;
                        end else if (bus_we && bus_wdata[0]) begin
                           if (unl_q) begin
                              state_d = ERASE;
                           end else begin
                              err_d  = 1'b1;
                              pe_set = 1'b1;
                           end
                        end
                     end
                     R_STATUS: begin
                        if (bus_we) begin
                           pe_clr = bus_wdata[2];
                           et_clr = bus_wdata[3];
                        end else begin
                           rdata_d = status;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         RD: begin
            fl_rd_en = 1'b1;
            state_d  = RD_DATA;
         end
         RD_DATA: begin
            rdata_d = fl_data_out;
            state_d = ACK;
         end
         PROG: begin
            fl_wr_en = 1'b1;
            state_d  = ACK;
         end
         ERASE: begin
            fl_erase_en = 1'b1;
            cnt_d       = '0;
            state_d     = ERASE_WAIT;
         end
         ERASE_WAIT: begin
            if (cnt_q == ERASE_TIMEOUT) begin
               err_d   = 1'b1;
               et_set  = 1'b1;
               unl_d   = 1'b0;
               state_d = ACK;
            end else if (cnt_q != 16'd0 && !fl_busy) begin
               unl_d   = 1'b0;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         unl_q   <= 1'b0;
         pe_q    <= 1'b0;
         et_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         unl_q   <= unl_d;
         cnt_q   <= cnt_d;
         pe_q    <= (pe_q & ~pe_clr) | pe_set;
         et_q    <= (et_q & ~et_clr) | et_set;
         if (state_q == IDLE && bus_req) begin
            addr_q  <= bus_addr[9:0];
            wdata_q <= bus_wdata;
         end
      end
   end

   assign bus_ack    = (state_q == ACK);
   assign bus_err    = bus_ack & err_q;
   assign bus_rdata  = bus_ack ? rdata_q : '0;
   assign fl_addr    = (state_q == IDLE) ? 12'd0 : {2'b00, addr_q};
   assign fl_data_in = (state_q == PROG) ? wdata_q : '0;

endmodule

// File: doc/flash_ctrl.md
FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 Parameter: UNLOCK_KEY, 32'hA5A5_5A5A, value that must be written to KEY to enable program/erase.
REQ-002 Parameter: ERASE_TIMEOUT, 16'd64, maximum cycles spent in ERASE_WAIT before abort.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 bus_req  in  1  access request; held high until bus_ack.
REQ-006 bus_we  in  1  1=write, 0=read; valid while bus_req.
REQ-007 bus_addr  in  13  word address; bit12=0 array region, bit12=1 register region.
REQ-008 bus_wdata  in  32  write data.
REQ-009 bus_ack  out  1  one-cycle completion pulse.
REQ-010 bus_err  out  1  error flag, valid only with bus_ack.
REQ-011 bus_rdata  out  32  read data, valid only with bus_ack.
REQ-012 fl_rd_en, fl_wr_en, fl_erase_en  out  1 each  flash strobes.
REQ-013 fl_addr  out  12  flash word address.
REQ-014 fl_data_in  out  32  flash write data.
REQ-015 fl_data_out  in  32  flash read data; valid the cycle after fl_rd_en is sampled.
REQ-016 fl_busy  in  1  flash erase in progress.

Function
REQ-017 FSM states SHALL be IDLE, RD, RD_DATA, PROG, ERASE, ERASE_WAIT, ACK.
REQ-018 IDLE with bus_req=1 SHALL latch bus_we/addr/wdata and leave IDLE the same edge; bus_req is ignored outside IDLE.
REQ-019 Array read: IDLE->RD (fl_rd_en=1, 1 cycle)->RD_DATA (bus_rdata<=fl_data_out)->ACK; bus_ack 3 cycles after the accepting edge.
REQ-020 Array write while unlocked: IDLE->PROG (fl_wr_en=1, fl_data_in=wdata, 1 cycle)->ACK.
REQ-021 Array write while locked: no strobe, IDLE->ACK with bus_err=1, STATUS.prog_err set.
REQ-022 Array access with bus_addr[11:10]!=0: no strobe, IDLE->ACK with bus_err=1, rdata=0.
REQ-023 fl_addr SHALL be {2'b00, latched addr[9:0]}; driven 0 in IDLE.
REQ-024 Registers (addr[1:0] in register region): 0=KEY (write-only, reads 0), 1=CMD (write-only, reads 0), 2=STATUS, 3=reserved (reads 0, writes ignored, no error); register access takes IDLE->ACK.
REQ-025 KEY write of UNLOCK_KEY sets unlocked=1; any other value clears it.
REQ-026 CMD write with wdata[0]=1 while unlocked: IDLE->ERASE (fl_erase_en=1, 1 cycle)->ERASE_WAIT; while locked: ACK with bus_err=1, prog_err set.
REQ-027 ERASE_WAIT SHALL start a 16-bit counter at 0, go to ACK when fl_busy=0 (count>=1), or at count=ERASE_TIMEOUT go to ACK with bus_err=1 and STATUS.erase_to set.
REQ-028 Any erase completion or timeout SHALL clear unlocked.
REQ-029 CMD write with wdata[1]=1 SHALL clear unlocked (lock); if bit0 also set, erase is not started.
REQ-030 STATUS read = {28'b0, erase_to, prog_err, 1'b0, unlocked}; STATUS write of 1 to bit2/bit3 clears that sticky bit; simultaneous set and clear, set wins.
REQ-031 ACK SHALL assert bus_ack for exactly one cycle then return to IDLE; a new request can be accepted the following cycle.
REQ-032 At most one flash strobe high in any cycle; strobes high only in RD, PROG, ERASE.

Reset
REQ-033 rst_n=0 sampled SHALL force IDLE, unlocked=0, prog_err=0, erase_to=0, counter=0, all outputs 0, including mid-erase or mid-read; no bus_ack is issued for the aborted request.

Verification
REQ-034 Read addr 0x005 after reset, flash word 0x1234_5678 -> fl_rd_en one cycle, bus_ack 3 cycles after acceptance, rdata 0x1234_5678, err=0.
REQ-035 Write 0x0010 data 0xDEAD_BEEF locked -> no fl_wr_en, ack with err=1, STATUS reads 0x4; write KEY=0xA5A5_5A5A, repeat -> fl_wr_en one cycle, err=0.
REQ-036 Unlock, CMD=1, fl_busy high 1 cycle -> fl_erase_en one cycle, ack err=0, STATUS.unlocked=0 afterwards.
REQ-037 Unlock, CMD=1, fl_busy stuck high -> ack err=1 after 64 cycles in ERASE_WAIT, STATUS=0x8; write STATUS=0x8 -> reads 0.
REQ-038 Read addr 0x0C00 -> no strobe, ack err=1, rdata 0.
REQ-039 rst_n low during ERASE_WAIT -> next edge all outputs 0, IDLE, no ack; subsequent read works normally.
